ahfp_addsub_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with a start/done handshake and clock enable.
- Generalises the single-precision add datapath: configurable exponent/mantissa width, true subtraction, round-to-nearest-even, and handling of zero, infinity and NaN.
- Sits as a multi-cycle custom-instruction unit beside the CPU; accepts one operation per enabled cycle.

---
 rtl/fp_pkg.sv | 48 ++++
 rtl/fp_lzc.sv | 21 ++
 rtl/ahfp_addsub_pipe.sv | 253 +++++++++++++++++++++++++
 tb/tb_ahfp_addsub_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and default-format constants for the ahfp floating-point pipeline.
// Holds default field widths, bias, canonical qNaN/inf words, operand class enum,
// the special-case flag bundle carried down the pipe, and the operand classifier.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
   localparam int FP_SIG_W = FP_MAN_W + 4;
   localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

   localparam logic [FP_W-1:0] FP_QNAN =
      {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
   localparam logic [FP_W-1:0] FP_INF =
      {1'b0, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   // Special-case outcome decided from the inputs, applied at the output.
   typedef struct packed {
      logic nan;
      logic inf;
      logic inf_sign;
      logic zero_neg;
   } fp_spec_t;

   // Exponent zero means zero: denormal inputs are flushed.
   function automatic fp_class_e fp_classify(
      input logic exp_zero,
      input logic exp_ones,
      input logic man_zero
   );
      fp_class_e c;
      c = CLS_NORM;
      if (exp_zero) begin
         c = CLS_ZERO;
      end else if (exp_ones) begin
         c = man_zero ? CLS_INF : CLS_NAN;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter used by the normalise stage.
// Ports: vec (W-bit input), count (number of leading zeros, W when vec is zero).
module fp_lzc #(
   parameter int W  = 27,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] count
);

   // Ascending scan: the highest set bit is the last to write.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (vec[i]) begin
            count = CW'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Pipelined floating-point add/subtract: input rank plus unpack, align, add,
// normalise and round/pack stages; round-to-nearest-even, denormals flushed.
// Ports: clk, reset (sync, active-high), clk_en (advance), start, op (1 = a-b),
//        dataa, datab (operands), result, done (one pulse per accepted start).
module ahfp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic                   start,
   input  logic                   op,
   input  logic [EXP_W+MAN_W:0]   dataa,
   input  logic [EXP_W+MAN_W:0]   datab,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   done
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 4;
   localparam int XW   = EXP_W + 2;
   localparam int LZW  = $clog2(SW + 1);
   localparam int SHW  = $clog2(MAN_W + 4);
   localparam int EMAX = (1 << EXP_W) - 1;

   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic             v;
      fp_spec_t         sp;
      logic             sa;
      logic             sb;
      logic [EXP_W-1:0] ea;
      logic [EXP_W-1:0] eb;
      logic [MAN_W:0]   ma;
      logic [MAN_W:0]   mb;
   } s1_t;

   typedef struct packed {
      logic             v;
      fp_spec_t         sp;
      logic             sa;
      logic             eff_sub;
      logic [EXP_W-1:0] ea;
      logic [SW-1:0]    ma;
      logic [SW-1:0]    mb;
   } s2_t;

   typedef struct packed {
      logic             v;
      fp_spec_t         sp;
      logic             s;
      logic [EXP_W-1:0] ea;
      logic [SW:0]      sum;
   } s3_t;

   typedef struct packed {
      logic          v;
      fp_spec_t      sp;
      logic          s;
      logic [XW-1:0] e;
      logic [SW-1:0] sig;
      logic          zero;
      logic          uf;
   } s4_t;

   logic         in_v;
   logic         in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;

   s1_t s1, s1_d;
   s2_t s2, s2_d;
   s3_t s3, s3_d;
   s4_t s4, s4_d;

   // Stage 1: unpack, classify, order by magnitude.
   logic             a_s, b_s;
   logic [EXP_W-1:0] a_e, b_e;
   logic [MAN_W-1:0] a_m, b_m;
   fp_class_e        a_c, b_c;
   logic [W-2:0]     a_mag, b_mag;
   logic             swap;

   always_comb begin
      a_s   = in_a[W-1];
      a_e   = in_a[W-2:MAN_W];
      a_m   = in_a[MAN_W-1:0];
      b_s   = in_b[W-1] ^ in_op;
      b_e   = in_b[W-2:MAN_W];
      b_m   = in_b[MAN_W-1:0];
      a_c   = fp_classify(a_e == '0, &a_e, a_m == '0);
      b_c   = fp_classify(b_e == '0, &b_e, b_m == '0);
      a_mag = (a_c == CLS_ZERO) ? '0 : in_a[W-2:0];
      b_mag = (b_c == CLS_ZERO) ? '0 : in_b[W-2:0];
      swap  = b_mag > a_mag;

      s1_d              = '0;
      s1_d.v            = in_v;
      s1_d.sp.nan       = (a_c == CLS_NAN) || (b_c == CLS_NAN) ||
                          ((a_c == CLS_INF) && (b_c == CLS_INF) &&
                           (a_s != b_s));
      s1_d.sp.inf       = (a_c == CLS_INF) || (b_c == CLS_INF);
      s1_d.sp.inf_sign  = (a_c == CLS_INF) ? a_s : b_s;
      // Only reachable as an exact zero when both operands are zero.
      s1_d.sp.zero_neg  = a_s & b_s;

      if (swap) begin
         s1_d.sa = b_s;
         s1_d.ea = b_e;
         s1_d.ma = {b_c == CLS_NORM, b_mag[MAN_W-1:0]};
         s1_d.sb = a_s;
         s1_d.eb = a_e;
         s1_d.mb = {a_c == CLS_NORM, a_mag[MAN_W-1:0]};
      end else begin
         s1_d.sa = a_s;
         s1_d.ea = a_e;
         s1_d.ma = {a_c == CLS_NORM, a_mag[MAN_W-1:0]};
         s1_d.sb = b_s;
         s1_d.eb = b_e;
         s1_d.mb = {b_c == CLS_NORM, b_mag[MAN_W-1:0]};
      end
   end

   // Stage 2: align B; shifted-out bits collapse into the sticky bit.
   logic [EXP_W-1:0] diff;
   logic [SHW-1:0]   sh;
   logic [2*SW-1:0]  wide;

   always_comb begin
      diff = s1.ea - s1.eb;
      if (32'(diff) > MAN_W + 3) begin
         sh = SHW'(MAN_W + 3);
      end else begin
         sh = SHW'(diff);
      end
      wide = {s1.mb, 3'b000, {SW{1'b0}}} >> sh;

      s2_d         = '0;
      s2_d.v       = s1.v;
      s2_d.sp      = s1.sp;
      s2_d.sa      = s1.sa;
      s2_d.eff_sub = s1.sa ^ s1.sb;
      s2_d.ea      = s1.ea;
      s2_d.ma      = {s1.ma, 3'b000};
      s2_d.mb      = wide[2*SW-1:SW] | SW'(|wide[SW-1:0]);
   end

   // Stage 3: add or subtract magnitudes; A >= B so no negative result.
   always_comb begin
      s3_d    = '0;
      s3_d.v  = s2.v;
      s3_d.sp = s2.sp;
      s3_d.s  = s2.sa;
      s3_d.ea = s2.ea;
      if (s2.eff_sub) begin
         s3_d.sum = {1'b0, s2.ma} - {1'b0, s2.mb};
      end else begin
         s3_d.sum = {1'b0, s2.ma} + {1'b0, s2.mb};
      end
   end

   // Stage 4: normalise.
   logic [LZW-1:0] lz;

   fp_lzc #(
      .W  (SW),
      .CW (LZW)
   ) u_lzc (
      .vec   (s3.sum[SW-1:0]),
      .count (lz)
   );

   always_comb begin
      s4_d      = '0;
      s4_d.v    = s3.v;
      s4_d.sp   = s3.sp;
      s4_d.s    = s3.s;
      s4_d.zero = s3.sum == '0;
      if (s3.sum[SW]) begin
         s4_d.sig = s3.sum[SW:1] | SW'(s3.sum[0]);
         s4_d.e   = XW'(s3.ea) + XW'(1);
      end else begin
         s4_d.sig = s3.sum[SW-1:0] << lz;
         s4_d.e   = XW'(s3.ea) - XW'(lz);
         s4_d.uf  = $signed(s4_d.e) <= 0;
      end
   end

   // Stage 5: round to nearest even, then special-case mux.
   logic             rnd;
   logic [MAN_W+1:0] mr;
   logic [MAN_W-1:0] man;
   logic [XW-1:0]    ef;
   logic             ovf;
   logic [W-1:0]     res;

   always_comb begin
      rnd = s4.sig[2] & (s4.sig[1] | s4.sig[0] | s4.sig[3]);
      mr  = {1'b0, s4.sig[SW-1:3]} + (MAN_W+2)'(rnd);
      // A rounding carry leaves 1.000..0 one binade up.
      man = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
      ef  = s4.e + XW'(mr[MAN_W+1]);
      ovf = $signed(ef) >= EMAX;

      if (s4.sp.nan) begin
         res = QNAN;
      end else if (s4.sp.inf) begin
         res = {s4.sp.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s4.zero) begin
         res = {s4.sp.zero_neg, {(W-1){1'b0}}};
      end else if (s4.uf) begin
         res = {s4.s, {(W-1){1'b0}}};
      end else if (ovf) begin
         res = {s4.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
         res = {s4.s, ef[EXP_W-1:0], man};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_v   <= 1'b0;
         in_op  <= 1'b0;
         in_a   <= '0;
         in_b   <= '0;
         s1     <= '0;
         s2     <= '0;
         s3     <= '0;
         s4     <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (clk_en) begin
         in_v  <= start;
         in_op <= op;
         in_a  <= dataa;
         in_b  <= datab;
         s1    <= s1_d;
         s2    <= s2_d;
         s3    <= s3_d;
         s4    <= s4_d;
         done  <= s4.v;
         if (s4.v) begin
            result <= res;
         end
      end
   end

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Bench for ahfp_addsub_pipe: directed vectors, streams with stall and reset,
// and random operands checked against an exact-arithmetic reference model.
module tb_ahfp_addsub_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] dataa = '0;
   logic [31:0] datab = '0;
   logic [31:0] result;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ahfp_addsub_pipe dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .op     (op),
      .dataa  (dataa),
      .datab  (datab),
      .result (result),
      .done   (done)
   );

   typedef struct {
      logic        v;
      logic [31:0] r;
      string       tag;
   } ent_t;

   ent_t        pipe[$];
   logic        exp_done = 1'b0;
   logic [31:0] exp_res = '0;
   string       exp_tag = "none";

   // Exact sum on a wide fixed-point grid (LSB = 2^-149), rounded once.
   function automatic logic [31:0] ref_fp(
      input logic [31:0] a,
      input logic [31:0] b,
      input logic        o
   );
      logic         sa, sb, s, up;
      int           ea, eb, e, p;
      logic [22:0]  fa, fb;
      logic [299:0] va, vb, mag, rem, half, one;
      logic [24:0]  keep;
      sa = a[31];
      sb = b[31] ^ o;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
         return 32'h7FC00000;
      if (ea == 255 && eb == 255)
         return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
      if (ea == 255) return {sa, 8'hFF, 23'h0};
      if (eb == 255) return {sb, 8'hFF, 23'h0};
      one = 300'(1);
      va = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
      vb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
      if (va == 0 && vb == 0) return {sa & sb, 31'h0};
      if (sa == sb) begin
         mag = va + vb;
         s = sa;
      end else if (va >= vb) begin
         mag = va - vb;
         s = sa;
      end else begin
         mag = vb - va;
         s = sb;
      end
      if (mag == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = p - 22;
      if (e <= 0) return {s, 31'h0};
      if (p > 23) begin
         keep = 25'(mag >> (p - 23));
         rem  = mag & ((one << (p - 23)) - one);
         half = one << (p - 24);
         up   = (rem > half) || (rem == half && keep[0]);
         keep = keep + 25'(up);
         if (keep[24]) begin
            keep = keep >> 1;
            e++;
         end
      end else begin
         keep = 25'(mag << (23 - p));
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, 8'(e), keep[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic flush_model();
      pipe.delete();
      repeat (5) pipe.push_back('{1'b0, 32'h0, "idle"});
      exp_done = 1'b0;
   endtask

   // One clock: drive, advance, update the latency model, compare.
   task automatic tick(input logic r, input logic en, input logic st,
                       input logic o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv,
                       input string tag);
      ent_t e;
      reset  = r;
      clk_en = en;
      start  = st;
      op     = o;
      dataa  = a;
      datab  = b;
      @(posedge clk);
      #1;
      if (r) begin
         flush_model();
         exp_res = 32'h0;
      end else if (en) begin
         pipe.push_back('{st, expv, tag});
         e = pipe.pop_front();
         exp_done = e.v;
         if (e.v) begin
            exp_res = e.r;
            exp_tag = e.tag;
         end
      end
      check({tag, " done"}, 32'(done), 32'(exp_done));
      if (exp_done) check({exp_tag, " result"}, result, exp_res);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "idle");
   endtask

   logic [31:0] da[13] = '{32'h3F800000, 32'h40400000, 32'h3F800000,
                           32'h80000000, 32'h3F800000, 32'h3F800001,
                           32'h3F7FFFFF, 32'h7F7FFFFF, 32'h7F800000,
                           32'h7FC12345, 32'hFF800000, 32'h00000001,
                           32'h00800001};
   logic [31:0] db[13] = '{32'h3F800000, 32'h3F800000, 32'h3F800000,
                           32'h80000000, 32'h33800000, 32'h33800000,
                           32'h33800000, 32'h7F7FFFFF, 32'h7F800000,
                           32'h3F800000, 32'h3F800000, 32'h00000000,
                           32'h00800000};
   logic        dop[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] dex[13] = '{32'h40000000, 32'h40000000, 32'h00000000,
                            32'h80000000, 32'h3F800000, 32'h3F800002,
                            32'h3F800000, 32'h7F800000, 32'h7FC00000,
                            32'h7FC00000, 32'hFF800000, 32'h00000000,
                            32'h00000000};
   logic [31:0] xs[8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                          32'h40800000, 32'h40A00000, 32'h40C00000,
                          32'h40E00000, 32'h41000000};

   initial begin
      logic [31:0] a, b;
      logic        o, en, st;
      int          ea, eb;

      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "reset");
      tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000,
           32'h0, "reset_start");
      check("reset result", result, 32'h0);

      // Single op, isolated: latency and done exclusivity.
      tick(1'b0, 1'b1, 1'b1, dop[0], da[0], db[0], dex[0], "dir0");
      idle(7);

      // Start while clk_en low must be ignored.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000,
           32'h0, "gated_start");
      idle(7);

      for (int i = 1; i < 13; i++)
         tick(1'b0, 1'b1, 1'b1, dop[i], da[i], db[i], dex[i],
              $sformatf("dir%0d", i));
      idle(7);

      // Stream with a two-cycle stall in the middle.
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b0, xs[i], 32'h3F800000,
              ref_fp(xs[i], 32'h3F800000, 1'b0), $sformatf("stall_x%0d", i + 1));
         if (i == 5) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, "stall");
            tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, "stall");
         end
      end
      idle(8);

      // Stream cut by a reset that also carries a start.
      for (int i = 0; i < 6; i++)
         tick(1'b0, 1'b1, 1'b1, 1'b0, xs[i], 32'h3F800000,
              ref_fp(xs[i], 32'h3F800000, 1'b0), $sformatf("rst_x%0d", i + 1));
      tick(1'b1, 1'b1, 1'b1, 1'b0, xs[6], 32'h3F800000, 32'h0, "rst_mid");
      idle(8);

      // Random operands, mostly with nearby exponents.
      for (int n = 0; n < 400; n++) begin
         ea = int'($urandom_range(1, 254));
         eb = ea + int'($urandom_range(0, 60)) - 30;
         if (eb < 0) eb = 0;
         if (eb > 255) eb = 255;
         a = {1'($urandom), 8'(ea), 23'($urandom)};
         b = {1'($urandom), 8'(eb), 23'($urandom)};
         if ($urandom_range(0, 15) == 0) a = $urandom;
         if ($urandom_range(0, 15) == 1) b = a;
         o  = 1'($urandom);
         en = $urandom_range(0, 9) != 0;
         st = $urandom_range(0, 4) != 0;
         tick(1'b0, en, st, o, a, b, ref_fp(a, b, o),
              $sformatf("rnd%0d_%h_%0b_%h", n, a, o, b));
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
